// File: rtl/bsg_mem_write_serializer_pkg.sv
// rtl/bsg_mem_write_serializer_pkg.sv - shared constants and buffer-entry type for the write serializer
package bsg_mem_write_serializer_pkg;

  // Number of write clients sharing the single memory write port
  localparam int num_clients_lp = 3;

  // Width of the round-robin pointer that names one client
  localparam int client_id_width_lp = $clog2(num_clients_lp);

  // Upper bounds on the address and data widths an entry can carry; only the
  // low addr_width_lp / width_p bits are meaningful, the rest stay zero
  localparam int max_addr_width_lp = 32;
  localparam int max_data_width_lp = 256;

  // One-entry write buffer owned by each client
  typedef struct packed {
    logic                         valid;
    logic [max_addr_width_lp-1:0] addr;
    logic [max_data_width_lp-1:0] data;
  } buf_entry_s;

endpackage

// File: rtl/bsg_mem_write_serializer_rr_arb.sv
// rtl/bsg_mem_write_serializer_rr_arb.sv - 3-way round-robin arbiter with one-hot grant
module bsg_mem_write_serializer_rr_arb
  import bsg_mem_write_serializer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_clients_lp-1:0] v_i,
  output logic [num_clients_lp-1:0] grant_o
);

  // Client that gets first look on the next arbitration
  logic [client_id_width_lp-1:0] r_ptr;
  logic [client_id_width_lp-1:0] w_gnt_idx;
  logic                          w_found;
  int                            w_idx;

  // Scan clients starting at the pointer and grant the first valid one
  always_comb begin
    grant_o   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < num_clients_lp; k++) begin
      w_idx = (int'(r_ptr) + k) % num_clients_lp;
      if (!w_found && v_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_gnt_idx      = client_id_width_lp'(w_idx);
        w_found        = 1'b1;
      end
    end
  end

  // Move priority to the client after the one just granted; hold when idle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      if (w_gnt_idx == client_id_width_lp'(num_clients_lp - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_mem_write_serializer.sv
// rtl/bsg_mem_write_serializer.sv - funnels three buffered write clients into one memory write port; BSG_MEM_WRITE_SERIALIZER_HAZARD_EN builds read-hazard comparators
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_mem_write_serializer
  import bsg_mem_write_serializer_pkg::*;
#(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     req0_v_i,
  input  logic [addr_width_lp-1:0] req0_addr_i,
  input  logic [width_p-1:0]       req0_data_i,
  output logic                     req0_ready_o,

  input  logic                     req1_v_i,
  input  logic [addr_width_lp-1:0] req1_addr_i,
  input  logic [width_p-1:0]       req1_data_i,
  output logic                     req1_ready_o,

  input  logic                     req2_v_i,
  input  logic [addr_width_lp-1:0] req2_addr_i,
  input  logic [width_p-1:0]       req2_data_i,
  output logic                     req2_ready_o,

  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,

  input  logic [addr_width_lp-1:0] r0_addr_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  input  logic [addr_width_lp-1:0] r2_addr_i,
  output logic                     r0_hazard_o,
  output logic                     r1_hazard_o,
  output logic                     r2_hazard_o
);

  logic [num_clients_lp-1:0] w_req_v;
  logic [addr_width_lp-1:0]  w_req_addr [num_clients_lp];
  logic [width_p-1:0]        w_req_data [num_clients_lp];
  logic [addr_width_lp-1:0]  w_rd_addr  [num_clients_lp];

  buf_entry_s                r_buf [num_clients_lp];
  logic                      r_live;
  logic [num_clients_lp-1:0] w_buf_v;
  logic [num_clients_lp-1:0] w_grant;
  logic [num_clients_lp-1:0] w_ready;
  logic [num_clients_lp-1:0] w_hs;
  logic [num_clients_lp-1:0] w_hazard;
  logic [addr_width_lp-1:0]  w_wr_addr;
  logic [width_p-1:0]        w_wr_data;
  logic                      w_unused_buf;

  assign w_req_v       = {req2_v_i, req1_v_i, req0_v_i};
  assign w_req_addr[0] = req0_addr_i;
  assign w_req_addr[1] = req1_addr_i;
  assign w_req_addr[2] = req2_addr_i;
  assign w_req_data[0] = req0_data_i;
  assign w_req_data[1] = req1_data_i;
  assign w_req_data[2] = req2_data_i;
  assign w_rd_addr[0]  = r0_addr_i;
  assign w_rd_addr[1]  = r1_addr_i;
  assign w_rd_addr[2]  = r2_addr_i;

  // Gather per-client valid bits for the arbiter and hazard logic
  always_comb begin
    w_buf_v = '0;
    for (int n = 0; n < num_clients_lp; n++) begin
      w_buf_v[n] = r_buf[n].valid;
    end
  end

  bsg_mem_write_serializer_rr_arb u_rr_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (w_buf_v),
    .grant_o   (w_grant)
  );

  // A client may hand over a new request when its buffer is free or draining
  // this cycle; r_live keeps ready low until the first edge out of reset
  assign w_ready = {num_clients_lp{r_live}} & (~w_buf_v | w_grant);
  assign w_hs    = w_req_v & w_ready;

  assign req0_ready_o = w_ready[0];
  assign req1_ready_o = w_ready[1];
  assign req2_ready_o = w_ready[2];

  // Enable handshakes starting with the first rising edge after reset release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Fill a buffer on handshake (refill wins over drain), otherwise empty it when granted
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int n = 0; n < num_clients_lp; n++) begin
        r_buf[n] <= '0;
      end
    end else begin
      for (int n = 0; n < num_clients_lp; n++) begin
        if (w_hs[n]) begin
          r_buf[n].valid <= 1'b1;
          r_buf[n].addr  <= max_addr_width_lp'(w_req_addr[n]);
          r_buf[n].data  <= max_data_width_lp'(w_req_data[n]);
        end else if (w_grant[n]) begin
          r_buf[n].valid <= 1'b0;
        end
      end
    end
  end

  // Steer the granted buffer onto the write port; zero when nothing is granted
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int n = 0; n < num_clients_lp; n++) begin
      if (w_grant[n]) begin
        w_wr_addr = r_buf[n].addr[addr_width_lp-1:0];
        w_wr_data = r_buf[n].data[width_p-1:0];
      end
    end
  end

  assign w_v_o    = |w_buf_v;
  assign w_addr_o = w_wr_addr;
  assign w_data_o = w_wr_data;

`ifdef BSG_MEM_WRITE_SERIALIZER_HAZARD_EN
  // Flag a read whose address matches any pending buffered write
  always_comb begin
    w_hazard = '0;
    for (int r = 0; r < num_clients_lp; r++) begin
      for (int n = 0; n < num_clients_lp; n++) begin
        if (r_buf[n].valid && (r_buf[n].addr[addr_width_lp-1:0] == w_rd_addr[r])) begin
          w_hazard[r] = 1'b1;
        end
      end
    end
  end
`else
  assign w_hazard = '0;
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^{w_rd_addr[0], w_rd_addr[1], w_rd_addr[2]};
`endif

  assign r0_hazard_o = w_hazard[0];
  assign r1_hazard_o = w_hazard[1];
  assign r2_hazard_o = w_hazard[2];

  // Upper entry bits beyond the configured widths are always zero
  assign w_unused_buf = ^{r_buf[0], r_buf[1], r_buf[2]};

`ifndef SYNTHESIS
  // Catch out-of-range accepted addresses, oversize widths and a malformed grant
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (width_p <= max_data_width_lp && addr_width_lp <= max_addr_width_lp);
      for (int n = 0; n < num_clients_lp; n++) begin
        if (w_hs[n]) begin
          assert (int'(w_req_addr[n]) < els_p);
        end
      end
      assert (!(|w_buf_v) || $onehot(w_grant));
    end
  end
`endif

endmodule

// File: doc/bsg_mem_write_serializer.md
BSG_MEM_WRITE_SERIALIZER -- requirements
Module: bsg_mem_write_serializer

Interface
REQ-001 Parameter width_p, no usable default (-1), data width of each write request and of the memory write port.
REQ-002 Parameter els_p, no usable default (-1), memory depth; all addresses must be less than els_p.
REQ-003 Parameter addr_width_lp, default `BSG_SAFE_CLOG2(els_p), address width.
REQ-004 Port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 Ports req{0,1,2}_v_i, input, 1 each, write request valid from client n.
REQ-007 Ports req{0,1,2}_addr_i, input, addr_width_lp each, write address of client n.
REQ-008 Ports req{0,1,2}_data_i, input, width_p each, write data of client n.
REQ-009 Ports req{0,1,2}_ready_o, output, 1 each, client n handshake completes when v_i and ready_o are both high on a rising edge.
REQ-010 Ports w_v_o, w_addr_o, w_data_o, output, 1 / addr_width_lp / width_p, single write port to a 3r1w sync memory.
REQ-011 Ports r{0,1,2}_addr_i, input, addr_width_lp each, read addresses the memory is about to sample.
REQ-012 Ports r{0,1,2}_hazard_o, output, 1 each, read address matches a buffered or issuing write.

Function
REQ-013 Each client SHALL own a one-entry buffer (valid, addr, data); three buffers total.
REQ-014 reqN_ready_o SHALL be high when buffer N is empty or buffer N is granted this cycle.
REQ-015 An accepted request SHALL fill buffer N on the same edge; earliest w_v_o for it is the next cycle (latency 1).
REQ-016 w_v_o SHALL be high whenever any buffer is valid; w_addr_o/w_data_o SHALL come from the granted buffer, driven from registers, with no combinational path from req*_i.
REQ-017 Grant SHALL be round-robin over valid buffers, starting from the client after the last granted one; the pointer SHALL advance only on a grant.
REQ-018 A granted buffer SHALL empty on the edge ending the grant cycle unless refilled by a simultaneous handshake, in which case it holds the new request.
REQ-019 Sustained throughput SHALL be one write per cycle; with all three clients saturated each SHALL receive exactly one grant in every three cycles.
REQ-020 Writes from the same client SHALL reach the memory in acceptance order; the order of same-address writes from different clients is the grant order.
REQ-021 rN_hazard_o SHALL be high iff rN_addr_i equals the addr of any valid buffer, combinationally.

Reset
REQ-022 On reset_n_i low, all buffers SHALL become invalid and the round-robin pointer SHALL select client 0 first, immediately and asynchronously.
REQ-023 During reset: w_v_o=0, every reqN_ready_o=0, every rN_hazard_o=0; w_addr_o/w_data_o=0.
REQ-024 Reset asserted mid-operation SHALL discard buffered writes; none SHALL be issued after release.
REQ-025 reqN_ready_o SHALL rise on the first rising edge after reset_n_i deasserts.

Configuration
REQ-026 Macro BSG_MEM_WRITE_SERIALIZER_HAZARD_EN: when defined, the comparators of REQ-021 are built; when undefined, all rN_hazard_o SHALL be tied to 0 and no comparator logic exists.

Structure
REQ-027 A shared package bsg_mem_write_serializer_pkg SHALL hold the client count constant (3) and the buffer-entry struct typedef (valid, addr, data).
REQ-028 The round-robin arbiter SHALL be one sub-module, bsg_mem_write_serializer_rr_arb (3 requests, one-hot grant, pointer register).
REQ-029 Simulation-only assertions SHALL flag any accepted address >= els_p and any grant that is not one-hot.

Verification
REQ-030 Reset release, req0 v=1 addr=5 data=0xAA -> cycle+1: w_v_o=1, w_addr_o=5, w_data_o=0xAA; then w_v_o=0.
REQ-031 All three clients hold v=1 for 9 cycles -> grants 0,1,2,0,1,2,0,1,2; each ready_o pulses only in its grant cycle.
REQ-032 Buffer 1 full with addr=3, r2_addr_i=3 -> r2_hazard_o=1 (macro defined) or 0 (undefined); r2_addr_i=4 -> 0.
REQ-033 reset_n_i low with all buffers full -> w_v_o=0 the same cycle; after release no stale write appears.
REQ-034 Client 0 streams addrs 0..7 back-to-back alone -> w_addr_o 0..7 on consecutive cycles, no bubbles.
